alu_muldiv: RTL and testbench

//  Parametrised multi-cycle ALU, successor to the single-cycle add/sub/and/or unit.

---
 rtl/alu_muldiv.sv | 179 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Brief    : Multi-cycle EXE-stage ALU. Single-cycle add/sub/and/or/xor/slt,
//            iterative unsigned shift-add multiply and restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       Aluc,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Hi,
    output logic             Z,
    output logic             V,
    output logic             Busy,
    output logic             Done
);

    localparam int                 c_cnt_w   = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [2:0] c_op_add  = 3'd0;
    localparam logic [2:0] c_op_sub  = 3'd1;
    localparam logic [2:0] c_op_and  = 3'd2;
    localparam logic [2:0] c_op_or   = 3'd3;
    localparam logic [2:0] c_op_xor  = 3'd4;
    localparam logic [2:0] c_op_slt  = 3'd5;
    localparam logic [2:0] c_op_mulu = 3'd6;
    localparam logic [2:0] c_op_divu = 3'd7;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nx;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;

    logic               w_accept;
    logic               w_multi;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_hi;
    logic               w_v;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;

    assign w_accept = (r_state == c_st_idle) && Start;
    // A zero divisor is finished in one cycle and never enters RUN.
    assign w_multi  = (Aluc == c_op_mulu) || ((Aluc == c_op_divu) && (Y != '0));
    assign w_last   = (r_state == c_st_run) && (r_cnt == c_cnt_last);

    assign Busy = (r_state == c_st_run);
    assign Z    = (R == '0);

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle: if (w_accept && w_multi) w_state_nx = c_st_run;
            c_st_run:  if (w_last)              w_state_nx = c_st_idle;
            default:                            w_state_nx = c_st_idle;
        endcase
    end

    assign w_sum  = X + Y;
    assign w_diff = X - Y;

    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_v   = 1'b0;
        case (Aluc)
            c_op_add: begin
                w_res = w_sum;
                w_v   = (X[WIDTH-1] == Y[WIDTH-1]) && (w_sum[WIDTH-1] != X[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff;
                w_v   = (X[WIDTH-1] != Y[WIDTH-1]) && (w_diff[WIDTH-1] != X[WIDTH-1]);
            end
            c_op_and: w_res = X & Y;
            c_op_or:  w_res = X | Y;
            c_op_xor: w_res = X ^ Y;
            c_op_slt: w_res = {{(WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
            c_op_divu: begin
                w_res = '1;
                w_hi  = X;
            end
            default: w_res = '0;
        endcase
    end

    // One iteration step; {r_hi, r_lo} is the product or {remainder, quotient}.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_opnd};

    always_comb begin
        w_hi_nx = w_mul_sum[WIDTH:1];
        w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_rem_diff[WIDTH]) begin
                w_hi_nx = w_rem_diff[WIDTH-1:0];
                w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nx = w_rem_sh[WIDTH-1:0];
                w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            R        <= '0;
            Hi       <= '0;
            V        <= 1'b0;
            Done     <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_accept) begin
                    if (w_multi) begin
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_is_div <= (Aluc == c_op_divu);
                        r_lo     <= (Aluc == c_op_divu) ? X : Y;
                        r_opnd   <= (Aluc == c_op_divu) ? Y : X;
                    end else begin
                        R    <= w_res;
                        Hi   <= w_hi;
                        V    <= w_v;
                        Done <= 1'b1;
                    end
                end
            end else begin
                r_hi <= w_hi_nx;
                r_lo <= w_lo_nx;
                if (w_last) begin
                    R    <= w_lo_nx;
                    Hi   <= w_hi_nx;
                    V    <= 1'b0;
                    Done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Brief    : Directed WIDTH=32 checks plus a randomized WIDTH=8 run against a
//            cycle-level arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn32, start32, z32, v32, busy32, done32;
    logic [31:0] x32, y32, r32, hi32;
    logic [2:0]  aluc32;

    logic        clrn8, start8, z8, v8, busy8, done8;
    logic [7:0]  x8, y8, r8, hi8;
    logic [2:0]  aluc8;

    int n_chk = 0;
    int n_err = 0;

    alu_muldiv #(.WIDTH(32)) u_dut32 (
        .Clk(clk), .Clrn(clrn32), .Start(start32), .X(x32), .Y(y32), .Aluc(aluc32),
        .R(r32), .Hi(hi32), .Z(z32), .V(v32), .Busy(busy32), .Done(done32)
    );

    alu_muldiv #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Clrn(clrn8), .Start(start8), .X(x8), .Y(y8), .Aluc(aluc8),
        .R(r8), .Hi(hi8), .Z(z8), .V(v8), .Busy(busy8), .Done(done8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operation semantics from plain integer arithmetic, w <= 32.
    function automatic void ref_alu(input int w, input logic [2:0] op,
                                    input logic [63:0] x, input logic [63:0] y,
                                    output logic [63:0] r, output logic [63:0] hi,
                                    output logic v, output bit multi);
        logic [63:0] mask;
        longint      sx, sy, ex, maxv, minv;
        mask = (64'd1 << w) - 64'd1;
        sx   = longint'(x);
        sy   = longint'(y);
        if (x[w-1]) sx = sx - (longint'(1) << w);
        if (y[w-1]) sy = sy - (longint'(1) << w);
        maxv  = (longint'(1) << (w-1)) - 1;
        minv  = -(longint'(1) << (w-1));
        r     = '0;
        hi    = '0;
        v     = 1'b0;
        multi = 1'b0;
        ex    = 0;
        case (op)
            3'd0: begin ex = sx + sy; r = (x + y) & mask; v = (ex > maxv) || (ex < minv); end
            3'd1: begin ex = sx - sy; r = (x - y) & mask; v = (ex > maxv) || (ex < minv); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = (sx < sy) ? 64'd1 : 64'd0;
            3'd6: begin r = (x * y) & mask; hi = (x * y) >> w; multi = 1'b1; end
            default: begin
                if (y == 0) begin r = mask; hi = x; end
                else begin r = x / y; hi = x % y; multi = 1'b1; end
            end
        endcase
    endfunction

    // ---------------- WIDTH=8 reference model, advanced at every edge -------
    logic [7:0] m_r = '0, m_hi = '0, p_r = '0, p_hi = '0;
    logic       m_v = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int         m_cnt = 0;
    int         n_acc = 0;
    bit         chk8_en = 1'b0;
    bit         rnd_done = 1'b0;

    always @(posedge clk) begin
        logic [63:0] rr, hh;
        logic        vv;
        bit          mm;
        if (!clrn8) begin
            m_r = '0; m_hi = '0; m_v = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_r = p_r; m_hi = p_hi; m_v = 1'b0;
                end
            end else if (start8) begin
                n_acc++;
                ref_alu(8, aluc8, {56'd0, x8}, {56'd0, y8}, rr, hh, vv, mm);
                if (mm) begin
                    m_busy = 1'b1; m_cnt = 8; p_r = rr[7:0]; p_hi = hh[7:0];
                end else begin
                    m_r = rr[7:0]; m_hi = hh[7:0]; m_v = vv; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk8_en) begin
            chk("r8",    r8,    m_r);
            chk("hi8",   hi8,   m_hi);
            chk("z8",    z8,    m_r == 8'd0);
            chk("v8",    v8,    m_v);
            chk("busy8", busy8, m_busy);
            chk("done8", done8, m_done);
        end
    end

    initial begin
        int cyc8;
        cyc8 = 0;
        clrn8 = 1'b0; start8 = 1'b0; x8 = '0; y8 = '0; aluc8 = '0;
        repeat (2) @(negedge clk);
        clrn8   = 1'b1;
        chk8_en = 1'b1;
        while (n_acc < 10000 && cyc8 < 80000) begin
            start8 = ($urandom_range(0, 3) != 0);
            aluc8  = 3'($urandom_range(0, 7));
            x8     = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            y8     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            clrn8  = ($urandom_range(0, 599) != 0);
            cyc8++;
            @(negedge clk);
        end
        start8 = 1'b0;
        clrn8  = 1'b1;
        repeat (12) @(negedge clk);
        rnd_done = 1'b1;
    end

    // ---------------- WIDTH=32 directed sequences ---------------------------
    task automatic issue32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        start32 = 1'b1; aluc32 = op; x32 = x; y32 = y;
        @(negedge clk);
        start32 = 1'b0; aluc32 = 3'($urandom); x32 = $urandom; y32 = $urandom;
    endtask

    // Edges elapsed after the accepting edge until Done is seen.
    task automatic wait32(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        while (done32 !== 1'b1 && lat < 100) begin
            if (busy32) bsy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run32(input string nm, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic [31:0] ehi,
                         input logic ev, input int elat);
        int          lat, bsy;
        logic [63:0] rr, hh;
        logic        vv;
        bit          mm;
        ref_alu(32, op, {32'd0, x}, {32'd0, y}, rr, hh, vv, mm);
        chk({nm, "_model_r"},  rr, {32'd0, er});
        chk({nm, "_model_hi"}, hh, {32'd0, ehi});
        chk({nm, "_model_v"},  vv, ev);
        issue32(op, x, y);
        wait32(lat, bsy);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_busy_cycles"}, bsy, elat);
        chk({nm, "_r"},  r32,  er);
        chk({nm, "_hi"}, hi32, ehi);
        chk({nm, "_z"},  z32,  er == 32'd0);
        chk({nm, "_v"},  v32,  ev);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done32, 1'b0);
    endtask

    initial begin
        int lat, bsy, n_done, guard;
        clrn32 = 1'b0; start32 = 1'b0; x32 = '0; y32 = '0; aluc32 = '0;
        repeat (2) @(negedge clk);
        chk("rst_r",    r32,    32'd0);
        chk("rst_hi",   hi32,   32'd0);
        chk("rst_z",    z32,    1'b1);
        chk("rst_v",    v32,    1'b0);
        chk("rst_busy", busy32, 1'b0);
        chk("rst_done", done32, 1'b0);
        clrn32 = 1'b1;
        @(negedge clk);

        run32("add_ovf",  3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'd0, 1'b1, 0);
        run32("sub_zero", 3'd1, 32'd5,        32'd5,        32'd0,        32'd0, 1'b0, 0);
        run32("sub_ovf",  3'd1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0, 1'b1, 0);
        run32("slt",      3'd5, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0, 1'b0, 0);
        run32("slt_no",   3'd5, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0, 1'b0, 0);
        run32("and",      3'd2, 32'hA5A5A5A5, 32'hFFFF0000, 32'hA5A50000, 32'd0, 1'b0, 0);
        run32("or",       3'd3, 32'hA5A5A5A5, 32'h0F0F0000, 32'hAFAFA5A5, 32'd0, 1'b0, 0);
        run32("xor",      3'd4, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 32'd0, 1'b0, 0);
        run32("mul_max",  3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32);
        run32("mul_sh",   3'd6, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 32);
        run32("div",      3'd7, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 32);
        run32("div_zero", 3'd7, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b0, 0);

        // Start while busy is dropped; Start in the Done cycle is taken.
        issue32(3'd6, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        start32 = 1'b1; aluc32 = 3'd0; x32 = 32'd1; y32 = 32'd2;
        @(negedge clk);
        start32 = 1'b0;
        wait32(lat, bsy);
        chk("ign_latency", lat, 26);
        chk("ign_r",  r32,  32'd15);
        chk("ign_hi", hi32, 32'd0);
        start32 = 1'b1; aluc32 = 3'd0; x32 = 32'd1; y32 = 32'd2;
        @(negedge clk);
        start32 = 1'b0;
        chk("b2b_done", done32, 1'b1);
        chk("b2b_r",    r32,    32'd3);
        @(negedge clk);
        chk("b2b_single", done32, 1'b0);

        // Reset in the middle of a multiply discards it.
        issue32(3'd6, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        clrn32 = 1'b0;
        @(negedge clk);
        clrn32 = 1'b1;
        chk("mrst_busy", busy32, 1'b0);
        chk("mrst_done", done32, 1'b0);
        chk("mrst_r",    r32,    32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 || busy32) n_done++;
        end
        chk("mrst_no_done", n_done, 0);
        run32("mul_after", 3'd6, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 32);

        guard = 0;
        while (!rnd_done && guard < 90000) begin
            @(negedge clk);
            guard++;
        end
        chk("rnd_finished", rnd_done, 1'b1);
        chk("rnd_count",    n_acc >= 10000, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
